instr_line_buffer: RTL and testbench
====================================

// Module: instr_line_buffer
// PURPOSE
//  Sits directly downstream of the PS/2 keyboard decoder. Consumes its per-key
//  event pulses (key_pressed/character, enter_pressed, bksp_pressed) and keeps
//  an editable line of up to MAX_CHARS ASCII characters. Feeds two consumers:
//  a display read port that shows the line being edited, and, on enter, a
//  valid/ready character stream to the instruction parser.
// PARAMETERS
//  MAX_CHARS   32  line capacity in characters
//  CHAR_W      8   stored character width (ASCII)
//  LEN_W       6   width of length counters, $clog2(MAX_CHARS+1)
// PORTS
//  clk_in         in   1       system clock; all logic on posedge
//  rst_in         in   1       asynchronous, active-low reset
//  key_pressed    in   1       1-cycle pulse: character[7:0] is a new char
//  character      in   16      ASCII in [7:0]; [15:8] ignored
//  enter_pressed  in   1       1-cycle pulse: commit the line
//  bksp_pressed   in   1       1-cycle pulse: delete the last char
//  disp_addr      in   5       display read index
//  disp_char      out  8       char at disp_addr, registered, latency 1
//  line_len       out  LEN_W   current number of stored chars
//  line_full      out  1       line_len == MAX_CHARS
//  busy           out  1       high in DRAIN
//  out_valid      out  1       stream beat valid
//  out_ready      in   1       parser accepts the beat
//  out_char       out  8       stream character
//  out_last       out  1       final beat of the committed line
//  drop_pulse     out  1       1-cycle pulse: an input event was discarded
// BEHAVIOUR
//  Reset (rst_in=0, async): state=EDIT, line_len=0, rd_ptr=0. disp_char,
//   out_valid, out_last, busy and drop_pulse are 0. Buffer contents need not
//   be cleared.
//  Input events are sampled on posedge. If more than one is high in a cycle,
//   the priority is enter > bksp > key. Only the winning event acts. The
//   losers are discarded silently, with no drop_pulse.
//  EDIT state:
//   key:   if line_len<MAX_CHARS then buf[line_len]<=character[7:0] and
//          line_len++. Else the buffer is unchanged and drop_pulse=1 on the
//          next cycle.
//   bksp:  if line_len>0 then line_len--. Else ignore, with no drop_pulse.
//   enter: if line_len>0 then go to DRAIN with rd_ptr<=0. If line_len==0,
//          ignore it, stay in EDIT, no stream beat.
//  DRAIN state:
//   busy=1 and out_valid=1.
//   out_char=buf[rd_ptr], driven combinationally from the buffer flops.
//   out_last=(rd_ptr==line_len-1).
//   out_char and out_last are stable while out_valid && !out_ready.
//   On out_valid && out_ready: if out_last, then line_len<=0 and state<=EDIT
//    (out_valid is 0 next cycle). Else rd_ptr++.
//   Every key, bksp or enter event in DRAIN is discarded, with drop_pulse=1 on
//    the next cycle.
//   The committed line is never modified while draining.
//  Throughput: one beat per cycle when out_ready is held high. A line of N
//   chars drains in N cycles, and EDIT resumes on cycle N+1 after entry.
//  Display port (both states): disp_char <= (disp_addr<line_len) ?
//   buf[disp_addr] : 8'h20 (space), registered one cycle after disp_addr.
//  line_full is combinational from line_len. line_len is always <= MAX_CHARS.
//  Reset asserted mid-DRAIN aborts the line immediately: out_valid falls
//   asynchronously, and no partial last beat is produced.
// TESTING
//  1. Keys 'a','d','d', enter, out_ready=1 -> beats 61,64,64 on 3 consecutive
//     cycles, out_last on the 3rd only; then line_len=0 and busy=0.
//  2. Line "add", out_ready toggled 1,0,0,1,1 -> beats accepted only when
//     ready=1; out_char/out_last held stable while stalled.
//  3. 33 keys 'x' -> line_len=32, line_full=1, one drop_pulse; disp_addr=31
//     reads 78; disp_addr=0 after a bksp still reads 78, line_full=0.
//  4. bksp at line_len=0 -> line_len stays 0, no drop_pulse. Enter at
//     line_len=0 -> no out_valid, busy=0.
//  5. key+bksp in same cycle at len 2 -> len 1, char not stored. Key during
//     DRAIN -> drop_pulse, streamed line unchanged.
//  6. Reset low during the 2nd beat of a 4-char drain -> out_valid=0
//     immediately. After release: EDIT, line_len=0, disp_char=20 for all
//     addresses.

Source files
------------

// File: rtl/instr_line_buffer.sv
// Editable command-line buffer between the PS/2 key decoder and the instruction parser.
// Collects characters in EDIT and streams the committed line out as valid/ready beats in DRAIN.
module instr_line_buffer #(
  parameter int MAX_CHARS = 32,
  parameter int CHAR_W    = 8,
  parameter int LEN_W     = 6
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              key_pressed,
  input  logic [15:0]       character,
  input  logic              enter_pressed,
  input  logic              bksp_pressed,
  input  logic [4:0]        disp_addr,
  output logic [CHAR_W-1:0] disp_char,
  output logic [LEN_W-1:0]  line_len,
  output logic              line_full,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHAR_W-1:0] out_char,
  output logic              out_last,
  output logic              drop_pulse
);

  localparam int ADDR_W = $clog2(MAX_CHARS);
  localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(MAX_CHARS);
  localparam logic [CHAR_W-1:0] SPACE   = CHAR_W'(8'h20);

  typedef enum logic {EDIT, DRAIN} state_t;

  state_t             state_q;
  logic [LEN_W-1:0]   line_len_q;
  logic [ADDR_W-1:0]  rd_ptr_q;
  logic [CHAR_W-1:0]  line_mem [MAX_CHARS];
  logic               key_win;
  logic               mem_we;
  logic               beat_done;
  logic               unused_char_hi;

  // Upper byte of the decoder's character bus carries no ASCII information.
  assign unused_char_hi = ^character[15:CHAR_W];

  // Priority enter > bksp > key: a key only counts when nothing else fires.
  assign key_win   = key_pressed && !enter_pressed && !bksp_pressed;
  assign mem_we    = (state_q == EDIT) && key_win && (line_len_q != MAX_LEN);
  assign beat_done = out_valid && out_ready && out_last;

  assign line_len  = line_len_q;
  assign line_full = (line_len_q == MAX_LEN);
  assign busy      = (state_q == DRAIN);
  assign out_valid = (state_q == DRAIN);
  assign out_char  = line_mem[rd_ptr_q];
  assign out_last  = (LEN_W'(rd_ptr_q) == line_len_q - LEN_W'(1));

  // NOTE: storage array has no reset; contents past line_len are never observed,
  // and leaving it unreset lets it map to plain flops/RAM without a reset tree.
  always_ff @(posedge clk_in) begin
    if (mem_we) line_mem[line_len_q[ADDR_W-1:0]] <= character[CHAR_W-1:0];
  end

  // NOTE: non-blocking assignments for all state so every register samples the
  // pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= EDIT;
      line_len_q <= '0;
      rd_ptr_q   <= '0;
      drop_pulse <= 1'b0;
      disp_char  <= '0;
    end else begin
      drop_pulse <= 1'b0;
      disp_char  <= (LEN_W'(disp_addr) < line_len_q) ? line_mem[disp_addr[ADDR_W-1:0]] : SPACE;
      case (state_q)
        EDIT: begin
          if (enter_pressed) begin
            if (line_len_q != '0) begin
              state_q  <= DRAIN;
              rd_ptr_q <= '0;
            end
          end else if (bksp_pressed) begin
            if (line_len_q != '0) line_len_q <= line_len_q - LEN_W'(1);
          end else if (key_pressed) begin
            if (line_len_q != MAX_LEN) line_len_q <= line_len_q + LEN_W'(1);
            else                       drop_pulse <= 1'b1;
          end
        end
        DRAIN: begin
          // The committed line is frozen here; any editing event is rejected.
          drop_pulse <= key_pressed || bksp_pressed || enter_pressed;
          if (beat_done) begin
            line_len_q <= '0;
            state_q    <= EDIT;
          end else if (out_ready) begin
            rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
          end
        end
        default: state_q <= EDIT;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_line_buffer.sv
// Directed bench for instr_line_buffer: an edit-vector table plus hand-written
// drain, stall, overflow, drop and mid-drain reset sequences.
module tb_instr_line_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        key_pressed, enter_pressed, bksp_pressed, out_ready;
  logic [15:0] character;
  logic [4:0]  disp_addr;
  logic [7:0]  disp_char, out_char;
  logic [5:0]  line_len;
  logic        line_full, busy, out_valid, out_last, drop_pulse;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  instr_line_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .key_pressed(key_pressed), .character(character),
    .enter_pressed(enter_pressed), .bksp_pressed(bksp_pressed),
    .disp_addr(disp_addr), .disp_char(disp_char),
    .line_len(line_len), .line_full(line_full), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
    .out_last(out_last), .drop_pulse(drop_pulse)
  );

  typedef struct {
    logic       key;
    logic [7:0] ch;
    logic       bksp;
    logic       enter;
    logic [4:0] addr;
    logic [5:0] exp_len;
    logic       exp_full;
    logic       exp_drop;
    logic [7:0] exp_disp;
    logic       exp_busy;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk_in);
    #1;
    key_pressed   = 1'b0;
    bksp_pressed  = 1'b0;
    enter_pressed = 1'b0;
  endtask

  task automatic press_key(input logic [7:0] ch);
    key_pressed = 1'b1;
    character   = {8'hA5, ch};
    tick();
  endtask

  task automatic press_enter();
    enter_pressed = 1'b1;
    tick();
  endtask

  // Drain the line, driving out_ready from pat (bit i on cycle i), checking every cycle.
  task automatic run_drain(input string name, input string line, input logic [15:0] pat, input int cycles);
    int idx = 0;
    for (int c = 0; c < cycles; c++) begin
      out_ready = pat[c];
      check({name, " valid"}, out_valid, 1'b1);
      check({name, " char"},  out_char,  (idx < line.len()) ? line[idx] : 8'h00);
      check({name, " last"},  out_last,  idx == line.len() - 1);
      tick();
      if (pat[c]) idx++;
    end
    out_ready = 1'b0;
    check({name, " beats"},   idx,       line.len());
    check({name, " end valid"}, out_valid, 1'b0);
    check({name, " end busy"},  busy,      1'b0);
    check({name, " end len"},   line_len,  6'd0);
  endtask

  initial begin
    int drops;
    rst_in = 1'b0; key_pressed = 1'b0; bksp_pressed = 1'b0; enter_pressed = 1'b0;
    out_ready = 1'b0; character = '0; disp_addr = '0;

    //                key  ch     bksp enter addr  len  full drop disp   busy
    vecs[0]  = '{1'b1, 8'h68, 1'b0, 1'b0, 5'd0, 6'd1, 1'b0, 1'b0, 8'h20, 1'b0};
    vecs[1]  = '{1'b1, 8'h69, 1'b0, 1'b0, 5'd0, 6'd2, 1'b0, 1'b0, 8'h68, 1'b0};
    vecs[2]  = '{1'b1, 8'h7a, 1'b1, 1'b0, 5'd1, 6'd1, 1'b0, 1'b0, 8'h69, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 6'd1, 1'b0, 1'b0, 8'h20, 1'b0};
    vecs[4]  = '{1'b1, 8'h71, 1'b0, 1'b0, 5'd0, 6'd2, 1'b0, 1'b0, 8'h68, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 6'd2, 1'b0, 1'b0, 8'h71, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 6'd1, 1'b0, 1'b0, 8'h68, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0, 8'h68, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0, 8'h20, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 6'd0, 1'b0, 1'b0, 8'h20, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0, 8'h20, 1'b0};

    #12;
    check("reset len",   line_len,   6'd0);
    check("reset valid", out_valid,  1'b0);
    check("reset busy",  busy,       1'b0);
    check("reset drop",  drop_pulse, 1'b0);
    check("reset disp",  disp_char,  8'h00);
    check("reset last",  out_last,   1'b0);
    rst_in = 1'b1;
    tick();

    // Edit table: priority, backspace, empty bksp/enter, display latency
    foreach (vecs[i]) begin
      key_pressed   = vecs[i].key;
      character     = {8'hFF, vecs[i].ch};
      bksp_pressed  = vecs[i].bksp;
      enter_pressed = vecs[i].enter;
      disp_addr     = vecs[i].addr;
      tick();
      check($sformatf("vec%0d len", i),   line_len,   vecs[i].exp_len);
      check($sformatf("vec%0d full", i),  line_full,  vecs[i].exp_full);
      check($sformatf("vec%0d drop", i),  drop_pulse, vecs[i].exp_drop);
      check($sformatf("vec%0d disp", i),  disp_char,  vecs[i].exp_disp);
      check($sformatf("vec%0d busy", i),  busy,       vecs[i].exp_busy);
      check($sformatf("vec%0d valid", i), out_valid,  vecs[i].exp_busy);
    end

    // Full-rate drain of "add"
    press_key(8'h61); press_key(8'h64); press_key(8'h64);
    out_ready = 1'b1;
    press_enter();
    run_drain("add_fast", "add", 16'h0007, 3);

    // Stalled drain: ready 1,0,0,1,1
    press_key(8'h61); press_key(8'h64); press_key(8'h64);
    press_enter();
    run_drain("add_stall", "add", 16'h0019, 5);

    // Overflow: 33 keys, exactly one drop
    drops = 0;
    for (int k = 0; k < 33; k++) begin
      press_key(8'h78);
      if (drop_pulse) drops++;
    end
    check("ovf len",   line_len,  6'd32);
    check("ovf full",  line_full, 1'b1);
    check("ovf drops", drops,     1);
    tick();
    check("ovf drop clears", drop_pulse, 1'b0);
    disp_addr = 5'd31;
    tick();
    check("ovf disp31", disp_char, 8'h78);
    disp_addr = 5'd0;
    bksp_pressed = 1'b1;
    tick();
    check("ovf disp0",  disp_char, 8'h78);
    check("ovf len31",  line_len,  6'd31);
    check("ovf notfull", line_full, 1'b0);
    check("ovf bksp nodrop", drop_pulse, 1'b0);
    for (int k = 0; k < 31; k++) begin
      bksp_pressed = 1'b1;
      tick();
    end
    check("clear len", line_len, 6'd0);

    // Key during drain is dropped and the line streams unchanged
    press_key(8'h61); press_key(8'h62);
    press_enter();
    check("drn busy", busy, 1'b1);
    press_key(8'h63);
    check("drn drop", drop_pulse, 1'b1);
    check("drn len",  line_len,   6'd2);
    bksp_pressed = 1'b1;
    tick();
    check("drn bksp drop", drop_pulse, 1'b1);
    check("drn bksp len",  line_len,   6'd2);
    run_drain("ab_drop", "ab", 16'h0003, 2);

    // Reset during the 2nd beat of a 4-char drain
    press_key(8'h77); press_key(8'h78); press_key(8'h79); press_key(8'h7a);
    press_enter();
    out_ready = 1'b1;
    check("rst beat0", out_char, 8'h77);
    tick();
    check("rst beat1", out_char,  8'h78);
    check("rst beat1 valid", out_valid, 1'b1);
    #2 rst_in = 1'b0;
    #1;
    check("rst async valid", out_valid, 1'b0);
    check("rst async busy",  busy,      1'b0);
    check("rst async len",   line_len,  6'd0);
    #2 rst_in = 1'b1;
    out_ready = 1'b0;
    tick();
    check("post rst len",   line_len,  6'd0);
    check("post rst valid", out_valid, 1'b0);
    for (int a = 0; a < 32; a++) begin
      disp_addr = 5'(a);
      tick();
      check($sformatf("post rst disp%0d", a), disp_char, 8'h20);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
